// File: rtl/sfifo_rd_pkg.sv
// Shared types and helpers for the FIFO read streamer.
package sfifo_rd_pkg;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  localparam int NUM_LEGAL_W = 4;
  localparam int LEGAL_WIDTHS [NUM_LEGAL_W] = '{8, 9, 16, 18};

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit width_legal(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_W; i++)
      if (LEGAL_WIDTHS[i] == w) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/sfifo_rd_obuf.sv
// Small circular output buffer: push at tail, pop at head, occupancy count.
module sfifo_rd_obuf
  import sfifo_rd_pkg::*;
#(
  parameter  int DW    = 18,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = occ_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [OW-1:0] occ_o
);

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]            occ_q;
  logic                     do_pop;

  assign do_pop = pop_i && (occ_q != '0);
  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

  // Storage, pointers (wrap naturally since DEPTH is a power of 2) and count; clear wins over push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, do_pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Upstream credit accounting must never let a write land on a full buffer
  always_ff @(posedge clk) begin
    if (rst_n && !clr_i)
      assert (!(push_i && !do_pop && occ_q == OW'(DEPTH)))
        else $error("sfifo_rd_obuf overflow");
  end

endmodule

// File: rtl/sfifo_rd_streamer.sv
// Drain stage for the 18K sync FIFO: credit-based POP issue, read-latency
// absorption buffer, valid/ready output, flush sequencing, sticky underrun.
// Optional BEAT_CNT output enabled by defining SFIFO_RD_STREAMER_BEAT_CNT_EN.
module sfifo_rd_streamer
  import sfifo_rd_pkg::*;
#(
  parameter  int DATA_WIDTH   = 18,
  parameter  int RD_LATENCY   = 1,
  parameter  int OBUF_DEPTH   = 4,
  parameter  int FLUSH_CYCLES = 2,
  localparam int OW           = occ_width(OBUF_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  FIFO_EMPTY,
  input  logic                  FIFO_UNDERRUN,
  input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
  output logic                  FIFO_POP,
  output logic                  FIFO_FLUSH,
  input  logic                  FLUSH,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic                  UNDERRUN_ERR,
  output logic [OW-1:0]         OCCUPANCY
`ifdef SFIFO_RD_STREAMER_BEAT_CNT_EN
  ,
  output logic [31:0]           BEAT_CNT
`endif
);

  localparam int         CW  = OW + 1;
  localparam logic [4:0] FC  = 5'(FLUSH_CYCLES);
  localparam logic [4:0] FC1 = 5'(FLUSH_CYCLES + 1);

  if (!width_legal(DATA_WIDTH)) begin : g_bad_width
    $error("DATA_WIDTH must be 8, 9, 16 or 18");
  end
  if (OBUF_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
    $error("OBUF_DEPTH must be at least RD_LATENCY+2");
  end

  state_e                state_q, state_d;
  logic                  en_q;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [4:0]            tmr_q, tmr_d;
  logic                  fflush_q, fflush_d;
  logic                  err_q, err_d;
  logic [OW-1:0]         occ;
  logic [CW-1:0]         inflight;
  logic                  pop, push, hs, flush_entry;

  assign flush_entry = (state_q == S_RUN) && FLUSH;
  assign push        = pipe_q[RD_LATENCY-1] && (state_q == S_RUN);
  assign M_VALID     = (state_q == S_RUN) && (occ != '0);
  assign hs          = M_VALID && M_READY;

  // Pops in flight = set bits in the read-latency shadow pipe
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + CW'(pipe_q[i]);
  end

  // Credit check counts buffered plus in-flight words; en_q holds POP low through reset
  always_comb begin
    pop = en_q && (state_q == S_RUN) && !FIFO_EMPTY &&
          (({1'b0, occ} + inflight) < CW'(OBUF_DEPTH));
  end

  // Shadow pipe shifts every cycle; flush entry drops any in-flight returns
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = pop;
    for (int i = 1; i < RD_LATENCY; i++)
      pipe_d[i] = pipe_q[i-1];
    if (flush_entry) pipe_d = '0;
  end

  // FSM next state: FLUSH holds FIFO_FLUSH for FLUSH_CYCLES then idles one cycle before RUN
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    fflush_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (FLUSH) begin
          state_d = S_FLUSH;
          tmr_d   = '0;
        end
      end
      S_FLUSH: begin
        tmr_d    = tmr_q + 5'd1;
        fflush_d = (tmr_q < FC);
        if (tmr_q == FC1) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Sticky underrun; a flush in the same cycle wins
  always_comb begin
    err_d = err_q;
    if (flush_entry)        err_d = 1'b0;
    else if (FIFO_UNDERRUN) err_d = 1'b1;
  end

  // Control registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_RUN;
      en_q     <= 1'b0;
      pipe_q   <= '0;
      tmr_q    <= '0;
      fflush_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= 1'b1;
      pipe_q   <= pipe_d;
      tmr_q    <= tmr_d;
      fflush_q <= fflush_d;
      err_q    <= err_d;
    end
  end

  sfifo_rd_obuf #(
    .DW    (DATA_WIDTH),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr_i  (flush_entry),
    .push_i (push),
    .din_i  (FIFO_DOUT),
    .pop_i  (hs),
    .head_o (M_DATA),
    .occ_o  (occ)
  );

  assign FIFO_POP     = pop;
  assign FIFO_FLUSH   = fflush_q;
  assign UNDERRUN_ERR = err_q;
  assign OCCUPANCY    = occ;

`ifdef SFIFO_RD_STREAMER_BEAT_CNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  // Saturating handshake counter, cleared on flush entry
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (flush_entry)                  beat_cnt_d = '0;
    else if (hs && beat_cnt_q != '1)  beat_cnt_d = beat_cnt_q + 32'd1;
  end

  // Beat counter register
  always_ff @(posedge CLK) begin
    if (!RESET_N) beat_cnt_q <= '0;
    else          beat_cnt_q <= beat_cnt_d;
  end

  assign BEAT_CNT = beat_cnt_q;
`endif

endmodule

// File: tb/tb_sfifo_rd_streamer.sv
// Directed bench with a FIFO model and a scoreboard-driven output monitor.
module tb_sfifo_rd_streamer;

  localparam int DW = 18;
  localparam int OW = 3;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          FIFO_EMPTY = 1'b1;
  logic          FIFO_UNDERRUN = 1'b0;
  logic [DW-1:0] FIFO_DOUT = '0;
  logic          FLUSH = 1'b0;
  logic          M_READY = 1'b0;
  logic          FIFO_POP, FIFO_FLUSH, M_VALID, UNDERRUN_ERR;
  logic [DW-1:0] M_DATA;
  logic [OW-1:0] OCCUPANCY;
`ifdef SFIFO_RD_STREAMER_BEAT_CNT_EN
  logic [31:0]   BEAT_CNT;
`endif

  sfifo_rd_streamer dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .FIFO_UNDERRUN (FIFO_UNDERRUN),
    .FIFO_DOUT     (FIFO_DOUT),
    .FIFO_POP      (FIFO_POP),
    .FIFO_FLUSH    (FIFO_FLUSH),
    .FLUSH         (FLUSH),
    .M_DATA        (M_DATA),
    .M_VALID       (M_VALID),
    .M_READY       (M_READY),
    .UNDERRUN_ERR  (UNDERRUN_ERR),
    .OCCUPANCY     (OCCUPANCY)
`ifdef SFIFO_RD_STREAMER_BEAT_CNT_EN
    ,
    .BEAT_CNT      (BEAT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] load_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stimulus writes take effect in the model one edge later; RD_LATENCY=1 read data
  always @(posedge CLK) begin
    if (FIFO_FLUSH === 1'b1) begin
      fifo_q.delete();
      FIFO_EMPTY <= 1'b1;
    end else begin
      if (FIFO_POP === 1'b1) begin
        if (fifo_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_on_empty: got POP=1 expected POP=0");
        end else begin
          FIFO_DOUT <= fifo_q.pop_front();
        end
      end
      while (load_q.size() != 0) fifo_q.push_back(load_q.pop_front());
      FIFO_EMPTY <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard monitor: every handshake must match the oldest expected word
  always @(negedge CLK) begin
    if (RESET_N && M_VALID && M_READY) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_unexpected: got %0h expected no beat", M_DATA);
      end else begin
        chk("beat_data", 32'(M_DATA), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] w, input bit expect_out);
    load_q.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  initial begin
    int vcnt, pcnt, fcnt, ffirst, waited;

    // Reset with a non-empty FIFO and ready downstream
    for (int i = 1; i <= 10; i++) load(DW'(i), 1'b1);
    M_READY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_pop",   32'(FIFO_POP), 0);
    chk("rst_fflush",32'(FIFO_FLUSH), 0);
    chk("rst_valid", 32'(M_VALID), 0);
    chk("rst_err",   32'(UNDERRUN_ERR), 0);
    chk("rst_occ",   32'(OCCUPANCY), 0);
    chk("rst_data",  32'(M_DATA), 0);
    cyc(1);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("rel_pop0", 32'(FIFO_POP), 0);
    @(negedge CLK);
    chk("rel_pop1", 32'(FIFO_POP), 1);

    // Streaming: first valid two cycles after first pop, then 10 back-to-back beats
    @(negedge CLK);
    chk("lat_valid0", 32'(M_VALID), 0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      vcnt += int'(M_VALID);
    end
    chk("stream_beats", 32'(vcnt), 10);
    @(negedge CLK);
    chk("stream_idle", 32'(M_VALID), 0);
    chk("stream_drained", 32'(exp_q.size()), 0);

    // Throttle: ready low, buffer fills to depth and popping stops
    cyc(1);
    M_READY = 1'b0;
    for (int i = 'h11; i <= 'h16; i++) load(DW'(i), 1'b1);
    cyc(12);
    @(negedge CLK);
    chk("thr_occ", 32'(OCCUPANCY), 4);
    chk("thr_pop", 32'(FIFO_POP), 0);
    chk("thr_fifo_left", 32'(fifo_q.size()), 2);
    chk("thr_hold_data", 32'(M_DATA), 32'h11);
    cyc(1);
    M_READY = 1'b1;
    cyc(12);
    chk("thr_drained", 32'(exp_q.size()), 0);
    chk("thr_occ0", 32'(OCCUPANCY), 0);

    // Empty boundary: single word gives exactly one pop and one beat
    load(DW'('h21), 1'b1);
    pcnt = 0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      pcnt += int'(FIFO_POP);
      vcnt += int'(M_VALID);
    end
    chk("one_pop", 32'(pcnt), 1);
    chk("one_beat", 32'(vcnt), 1);
    chk("one_empty", 32'(FIFO_EMPTY), 1);
    chk("one_drained", 32'(exp_q.size()), 0);

    // Flush with three words buffered and one pop in flight
    cyc(1);
    M_READY = 1'b0;
    for (int i = 'h31; i <= 'h34; i++) load(DW'(i), 1'b0);
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (OCCUPANCY != 3 && waited < 20);
    chk("fl_pre_occ", 32'(OCCUPANCY), 3);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    chk("fl_valid0", 32'(M_VALID), 0);
    chk("fl_occ0", 32'(OCCUPANCY), 0);
    fcnt = 0;
    pcnt = 0;
    vcnt = 0;
    ffirst = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (FIFO_FLUSH && ffirst < 0) ffirst = i;
      fcnt += int'(FIFO_FLUSH);
      pcnt += int'(FIFO_POP);
      vcnt += int'(M_VALID);
    end
    chk("fl_len", 32'(fcnt), 2);
    chk("fl_start", 32'(ffirst), 0);
    chk("fl_no_pop", 32'(pcnt), 0);
    chk("fl_discard", 32'(vcnt), 0);
    load(DW'('h41), 1'b1);
    load(DW'('h42), 1'b1);
    load(DW'('h43), 1'b1);
    M_READY = 1'b1;
    cyc(12);
    chk("fl_resume", 32'(exp_q.size()), 0);

    // Underrun: sticky from the next cycle, cleared by flush even with a coincident underrun
    FIFO_UNDERRUN = 1'b1;
    @(negedge CLK);
    chk("ur_same", 32'(UNDERRUN_ERR), 0);
    cyc(1);
    FIFO_UNDERRUN = 1'b0;
    @(negedge CLK);
    chk("ur_set", 32'(UNDERRUN_ERR), 1);
    cyc(3);
    @(negedge CLK);
    chk("ur_hold", 32'(UNDERRUN_ERR), 1);
    cyc(1);
    FLUSH = 1'b1;
    FIFO_UNDERRUN = 1'b1;
    cyc(1);
    FLUSH = 1'b0;
    FIFO_UNDERRUN = 1'b0;
    @(negedge CLK);
    chk("ur_flush_clr", 32'(UNDERRUN_ERR), 0);
    cyc(8);
    chk("ur_stay_clr", 32'(UNDERRUN_ERR), 0);

`ifdef SFIFO_RD_STREAMER_BEAT_CNT_EN
    // Beat counter: 7 handshakes, flush clears, then saturation
    for (int i = 'h51; i <= 'h57; i++) load(DW'(i), 1'b1);
    cyc(14);
    chk("bc_seven", BEAT_CNT, 7);
    FLUSH = 1'b1;
    cyc(1);
    FLUSH = 1'b0;
    @(negedge CLK);
    chk("bc_flush", BEAT_CNT, 0);
    cyc(8);
    force dut.beat_cnt_q = 32'hFFFF_FFFF;
    cyc(1);
    release dut.beat_cnt_q;
    load(DW'('h61), 1'b1);
    cyc(8);
    chk("bc_sat", BEAT_CNT, 32'hFFFF_FFFF);
`endif

    cyc(2);
    chk("final_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
